collision_job_scheduler: RTL and testbench

Sequences the parallel collision searcher array across a queue of search jobs so software does not have to poll and restart every target by hand. It buffers pending 5-bit targets in a small FIFO and launches one search at a time with a start pulse. Each search ends on a searcher hit or on a cycle-budget timeout, which aborts it. The block then flushes the searchers and presents the outcome through a valid/ready result port. It sits between the custom-instruction decode logic and the searcher array, sharing the message already loaded in the message collector.

---
 rtl/collision_job_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_collision_job_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/collision_job_scheduler.sv
// Collision search job scheduler: queues 5-bit targets and runs one
// searcher-array search at a time, reporting hit or timeout results.
module collision_job_scheduler #(
  parameter int JOB_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             wClock,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [4:0]       job_target,
  output logic             job_ready,
  input  logic [31:0]      timeout_cycles,
  output logic             search_start,
  output logic [4:0]       search_target,
  output logic             search_abort,
  input  logic             search_done,
  input  logic [31:0]      search_result,
  output logic             res_valid,
  output logic             res_found,
  output logic [31:0]      res_value,
  output logic [4:0]       res_target,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] jobs_completed
);

  localparam int PW = $clog2(JOB_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SEARCH,
    S_FLUSH,
    S_REPORT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [4:0]       r_mem [JOB_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_job_ready;

  logic [31:0]      r_timer;
  logic             r_timer_en;
  logic [FW-1:0]    r_flush_cnt;

  logic [4:0]       r_search_target;
  logic             r_res_valid;
  logic             r_res_found;
  logic [31:0]      r_res_value;
  logic [4:0]       r_res_target;
  logic [CNT_W-1:0] r_jobs_completed;

  logic w_push;
  logic w_pop;
  logic w_start;
  logic w_abort;
  logic w_hit;
  logic w_tmo;
  logic w_flush_done;
  logic w_accept;
  logic w_dec;

  assign w_push = job_valid & r_job_ready;
  assign w_tmo  = r_timer_en && (r_timer == 32'd1);

  always_comb begin
    w_next       = r_state;
    w_pop        = 1'b0;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_hit        = 1'b0;
    w_flush_done = 1'b0;
    w_accept     = 1'b0;
    w_dec        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && !r_res_valid) begin
          w_pop  = 1'b1;
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_start = 1'b1;
        w_next  = S_SEARCH;
      end
      S_SEARCH: begin
        // a hit in the timeout cycle wins: the result is real
        if (search_done) begin
          w_hit  = 1'b1;
          w_next = S_FLUSH;
        end else if (w_tmo) begin
          w_abort = 1'b1;
          w_next  = S_FLUSH;
        end else begin
          w_dec = r_timer_en;
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
          w_flush_done = 1'b1;
          w_next       = S_REPORT;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          w_accept = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wClock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge wClock) begin
    if (w_push) r_mem[r_wptr] <= job_target;
  end

  always_ff @(posedge wClock or posedge reset) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_job_ready <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count     <= w_count_nxt;
      r_job_ready <= (w_count_nxt != CW'(JOB_DEPTH));
    end
  end

  always_ff @(posedge wClock or posedge reset) begin
    if (reset) begin
      r_search_target  <= '0;
      r_timer          <= '0;
      r_timer_en       <= 1'b0;
      r_flush_cnt      <= '0;
      r_res_valid      <= 1'b0;
      r_res_found      <= 1'b0;
      r_res_value      <= '0;
      r_res_target     <= '0;
      r_jobs_completed <= '0;
    end else begin
      if (w_pop) begin
        r_search_target <= r_mem[r_rptr];
        r_timer         <= timeout_cycles;
        r_timer_en      <= (timeout_cycles != 32'd0);
      end
      if (w_dec) r_timer <= r_timer - 32'd1;
      if (w_hit) begin
        r_res_found <= 1'b1;
        r_res_value <= search_result;
      end
      if (w_abort) begin
        r_res_found <= 1'b0;
        r_res_value <= '0;
      end
      if (w_hit || w_abort)      r_flush_cnt <= '0;
      else if (r_state == S_FLUSH) r_flush_cnt <= r_flush_cnt + FW'(1);
      if (w_flush_done) begin
        r_res_valid  <= 1'b1;
        r_res_target <= r_search_target;
      end
      if (w_accept) begin
        r_res_valid      <= 1'b0;
        r_jobs_completed <= r_jobs_completed + CNT_W'(1);
      end
    end
  end

  assign job_ready      = r_job_ready;
  assign search_start   = w_start;
  assign search_target  = r_search_target;
  assign search_abort   = w_abort;
  assign res_valid      = r_res_valid;
  assign res_found      = r_res_found;
  assign res_value      = r_res_value;
  assign res_target     = r_res_target;
  assign busy           = (r_state != S_IDLE) || (r_count != '0);
  assign jobs_completed = r_jobs_completed;

endmodule

// File: tb/tb_collision_job_scheduler.sv
// Random-stimulus bench for collision_job_scheduler against a
// timestamp/queue reference model of the job lifecycle.
module tb_collision_job_scheduler;

  localparam int DEPTH = 4;
  localparam int FL    = 2;
  localparam int CNTW  = 16;

  logic            wClock = 1'b0;
  logic            reset;
  logic            job_valid;
  logic [4:0]      job_target;
  logic            job_ready;
  logic [31:0]     timeout_cycles;
  logic            search_start;
  logic [4:0]      search_target;
  logic            search_abort;
  logic            search_done;
  logic [31:0]     search_result;
  logic            res_valid;
  logic            res_found;
  logic [31:0]     res_value;
  logic [4:0]      res_target;
  logic            res_ready;
  logic            busy;
  logic [CNTW-1:0] jobs_completed;

  collision_job_scheduler #(
    .JOB_DEPTH(DEPTH),
    .FLUSH_CYCLES(FL),
    .CNT_W(CNTW)
  ) dut (
    .wClock(wClock),
    .reset(reset),
    .job_valid(job_valid),
    .job_target(job_target),
    .job_ready(job_ready),
    .timeout_cycles(timeout_cycles),
    .search_start(search_start),
    .search_target(search_target),
    .search_abort(search_abort),
    .search_done(search_done),
    .search_result(search_result),
    .res_valid(res_valid),
    .res_found(res_found),
    .res_value(res_value),
    .res_target(res_target),
    .res_ready(res_ready),
    .busy(busy),
    .jobs_completed(jobs_completed)
  );

  always #5 wClock = ~wClock;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: job queue plus timestamps of the active job
  int          q[$];
  bit          m_have;
  bit          m_ended;
  bit          m_found;
  int          m_launch;
  int          m_end;
  int          m_T;
  int          m_tgt;
  logic [31:0] m_val;
  int          m_comp;
  int          cyc;

  task automatic model_clear();
    q.delete();
    m_have  = 0;
    m_ended = 0;
    m_comp  = 0;
  endtask

  task automatic run_phase(input int n, input int pp, input int pr,
                           input bit want_rst);
    bit wr = want_rst;
    for (int i = 0; i < n; i++) begin
      int sz;
      bit srch, e_start, e_abort, e_rv, had;
      @(posedge wClock);
      #1;
      cyc++;
      reset = 1'b0;
      srch = m_have && !m_ended && (cyc > m_launch);
      if (wr && srch && q.size() >= 2) begin
        reset       = 1'b1;
        job_valid   = 1'b0;
        search_done = 1'b0;
        res_ready   = 1'b0;
        #1;
        chk("rst_job_ready", job_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_completed", jobs_completed, 0);
        chk("rst_start", search_start, 0);
        chk("rst_abort", search_abort, 0);
        model_clear();
        wr = 0;
        continue;
      end
      job_valid      = ($urandom_range(99) < pp);
      job_target     = 5'($urandom_range(31));
      res_ready      = ($urandom_range(99) < pr);
      timeout_cycles = ($urandom_range(5) == 0) ? 32'd0
                                                : 32'($urandom_range(1, 12));
      search_done    = ($urandom_range(5) == 0);
      search_result  = $urandom;
      #1;
      sz      = q.size();
      had     = m_have;
      e_start = m_have && (cyc == m_launch);
      e_abort = srch && (m_T != 0) && (cyc == m_launch + m_T) && !search_done;
      e_rv    = m_have && m_ended && (cyc >= m_end + FL + 1);
      chk("job_ready", job_ready, (sz < DEPTH));
      chk("busy", busy, (m_have || sz > 0));
      chk("search_start", search_start, e_start);
      chk("search_abort", search_abort, e_abort);
      chk("res_valid", res_valid, e_rv);
      chk("jobs_completed", jobs_completed, 32'(m_comp % (1 << CNTW)));
      if (m_have && cyc >= m_launch)
        chk("search_target", search_target, m_tgt);
      if (e_rv) begin
        chk("res_found", res_found, m_found);
        chk("res_value", res_value, m_val);
        chk("res_target", res_target, m_tgt);
      end
      if (e_rv && res_ready) begin
        m_have = 0;
        m_comp++;
      end else if (!had && sz > 0) begin
        m_have   = 1;
        m_ended  = 0;
        m_tgt    = q.pop_front();
        m_launch = cyc + 1;
        m_T      = int'(timeout_cycles);
      end else if (srch) begin
        if (search_done) begin
          m_ended = 1;
          m_found = 1;
          m_val   = search_result;
          m_end   = cyc;
        end else if (m_T != 0 && cyc == m_launch + m_T) begin
          m_ended = 1;
          m_found = 0;
          m_val   = 0;
          m_end   = cyc;
        end
      end
      if (job_valid && sz < DEPTH) q.push_back(int'(job_target));
    end
  endtask

  initial begin
    reset          = 1'b1;
    job_valid      = 1'b0;
    job_target     = '0;
    timeout_cycles = '0;
    search_done    = 1'b0;
    search_result  = '0;
    res_ready      = 1'b0;
    model_clear();
    cyc = 0;
    #12;
    chk("init_job_ready", job_ready, 1);
    chk("init_res_valid", res_valid, 0);
    chk("init_busy", busy, 0);
    chk("init_start", search_start, 0);
    chk("init_abort", search_abort, 0);
    chk("init_completed", jobs_completed, 0);
    chk("init_res_value", res_value, 0);
    run_phase(400, 30, 60, 0);
    run_phase(300, 90, 10, 0);
    run_phase(300, 80, 50, 1);
    run_phase(400, 40, 70, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
